// File: rtl/acc_seg_if.sv
// acc_seg_if: segment push handshake from buf_exec into the sequencer FIFO
interface acc_seg_if #(parameter int DT_W = 32, parameter int STEPS_W = 32);
  logic seg_valid;
  logic seg_ready;
  logic [DT_W-1:0] seg_dt;
  logic [STEPS_W-1:0] seg_steps;
  modport master(output seg_valid, seg_dt, seg_steps, input seg_ready);
  modport slave(input seg_valid, seg_dt, seg_steps, output seg_ready);
endinterface

// File: rtl/acc_seg_sequencer.sv
// acc_seg_sequencer: runs FIFO-fed {dt, steps} segments as start_calc/load_speeds pulses, with abort/decel handling
module acc_seg_sequencer #(
  parameter int DT_W = 32,
  parameter int STEPS_W = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int ABORT_CH = 8,
  parameter int MIN_LOAD_CYCLES = 100,
  localparam int LW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                clk,
  input  logic                reset,
  acc_seg_if.slave            seg,
  output logic [LW-1:0]       fifo_level,
  input  logic                start,
  input  logic                abort,
  input  logic [ABORT_CH-1:0] pending_aborts,
  output logic                start_calc,
  input  logic                acc_calc_done,
  output logic                load_speeds,
  output logic                global_abort,
  output logic                done,
  output logic                busy,
  output logic                err_overflow,
  output logic                err_underrun,
  output logic                err_abort,
  output logic [DT_W-1:0]     dt,
  output logic [STEPS_W-1:0]  steps
);
  localparam int AW = LW - 1;
  typedef enum logic [3:0] {
    IDLE, FIRST_CALC, CALC, WAIT_CALC, WAIT, SEG_END, LAST,
    ABORT, ABORT_FIRST_CALC, ABORT_CALC, ABORT_WAIT_CALC, ABORT_WAIT
  } state_t;
  state_t state, state_n;
  logic [DT_W-1:0] mem_dt [FIFO_DEPTH];
  logic [STEPS_W-1:0] mem_steps [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [DT_W-1:0] dt_limit, pend_dt, dt_n, dt_lim_n, pend_dt_n, head_dt;
  logic [STEPS_W-1:0] steps_limit, pend_steps, steps_n, st_lim_n, pend_st_n, head_st;
  logic seam, seam_n, pop, flush, push, ovf, aborting, empty, enter_abort;
  logic dt_exp, slack_exp, steps_more;
  logic start_calc_n, load_n, ga_n, done_n, busy_n, eo_n, eu_n, ea_n;
  assign aborting = state >= ABORT;
  assign empty = fifo_level == '0;
  assign seg.seg_ready = fifo_level != LW'(FIFO_DEPTH) && !aborting;
  assign push = seg.seg_valid && seg.seg_ready;
  assign ovf = seg.seg_valid && !seg.seg_ready;
  assign head_dt = mem_dt[rd_ptr];
  assign head_st = mem_steps[rd_ptr] == '0 ? STEPS_W'(1) : mem_steps[rd_ptr];
  assign dt_exp = {1'b0, dt} + (DT_W+1)'(1) >= {1'b0, dt_limit};
  assign slack_exp = {1'b0, dt} + (DT_W+1)'(MIN_LOAD_CYCLES) >= {1'b0, dt_limit};
  assign steps_more = {1'b0, steps} + (STEPS_W+1)'(1) < {1'b0, steps_limit};
  // seam: a mid-motion segment was popped; its limits apply when the running interval expires
  always_comb begin
    state_n = state;
    dt_n = &dt ? dt : dt + DT_W'(1);
    steps_n = steps;
    dt_lim_n = dt_limit;
    st_lim_n = steps_limit;
    pend_dt_n = pend_dt;
    pend_st_n = pend_steps;
    seam_n = seam;
    pop = 1'b0;
    flush = 1'b0;
    enter_abort = 1'b0;
    start_calc_n = 1'b0;
    load_n = 1'b0;
    ga_n = 1'b0;
    done_n = 1'b0;
    busy_n = busy;
    eo_n = err_overflow || ovf;
    eu_n = err_underrun;
    ea_n = err_abort;
    case (state)
      IDLE: begin
        dt_n = '0;
        if (start) begin
          eo_n = ovf;
          eu_n = empty;
          ea_n = 1'b0;
          done_n = empty || head_dt == '0;
          if (!empty) begin
            pop = 1'b1;
            dt_lim_n = head_dt;
            st_lim_n = head_st;
            if (head_dt != '0) begin
              busy_n = 1'b1;
              start_calc_n = 1'b1;
              steps_n = '0;
              state_n = FIRST_CALC;
            end
          end
        end
      end
      FIRST_CALC, ABORT_FIRST_CALC: if (acc_calc_done) begin
        load_n = 1'b1;
        dt_n = '0;
        state_n = state == FIRST_CALC ? CALC : ABORT_CALC;
      end
      CALC, ABORT_CALC: begin
        start_calc_n = 1'b1;
        state_n = state == CALC ? WAIT_CALC : ABORT_WAIT_CALC;
      end
      WAIT_CALC: if (acc_calc_done) state_n = seam || steps_more ? WAIT : SEG_END;
      WAIT: if (dt_exp) begin
        dt_n = '0;
        load_n = 1'b1;
        steps_n = seam ? '0 : steps + STEPS_W'(1);
        dt_lim_n = seam ? pend_dt : dt_limit;
        st_lim_n = seam ? pend_steps : steps_limit;
        seam_n = 1'b0;
        state_n = CALC;
      end
      SEG_END: begin
        if (!empty) begin
          pop = 1'b1;
          if (head_dt != '0) begin
            pend_dt_n = head_dt;
            pend_st_n = head_st;
            seam_n = 1'b1;
            steps_n = '0;
            start_calc_n = 1'b1;
            state_n = WAIT_CALC;
          end else state_n = LAST;
        end else if (slack_exp) begin
          eu_n = 1'b1;
          enter_abort = 1'b1;
        end
      end
      ABORT: begin
        start_calc_n = 1'b1;
        state_n = ABORT_FIRST_CALC;
      end
      ABORT_WAIT_CALC: if (acc_calc_done) state_n = ABORT_WAIT;
      LAST, ABORT_WAIT: if (dt_exp) begin
        load_n = 1'b1;
        dt_n = '0;
        if (state == LAST || pending_aborts == '0) begin
          done_n = 1'b1;
          busy_n = 1'b0;
          dt_lim_n = '0;
          st_lim_n = '0;
          steps_n = '0;
          state_n = IDLE;
        end else state_n = ABORT_CALC;
      end
      default: state_n = IDLE;
    endcase
    if ((abort && !aborting) || enter_abort) begin
      state_n = ABORT;
      ga_n = 1'b1;
      flush = 1'b1;
      pop = 1'b0;
      busy_n = 1'b1;
      dt_n = '0;
      steps_n = '0;
      seam_n = 1'b0;
      start_calc_n = 1'b0;
      load_n = 1'b0;
      done_n = 1'b0;
      eo_n = err_overflow || ovf;
      eu_n = err_underrun || enter_abort;
      ea_n = err_abort || abort;
    end
  end
  always_ff @(posedge clk) if (push) begin
    mem_dt[wr_ptr] <= seg.seg_dt;
    mem_steps[wr_ptr] <= seg.seg_steps;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      fifo_level <= '0;
      dt <= '0;
      steps <= '0;
      dt_limit <= '0;
      steps_limit <= '0;
      pend_dt <= '0;
      pend_steps <= '0;
      seam <= 1'b0;
      start_calc <= 1'b0;
      load_speeds <= 1'b0;
      global_abort <= 1'b0;
      done <= 1'b0;
      busy <= 1'b0;
      err_overflow <= 1'b0;
      err_underrun <= 1'b0;
      err_abort <= 1'b0;
    end else begin
      state <= state_n;
      wr_ptr <= flush ? '0 : wr_ptr + AW'(push);
      rd_ptr <= flush ? '0 : rd_ptr + AW'(pop);
      fifo_level <= flush ? '0 : fifo_level + LW'(push) - LW'(pop);
      dt <= dt_n;
      steps <= steps_n;
      dt_limit <= dt_lim_n;
      steps_limit <= st_lim_n;
      pend_dt <= pend_dt_n;
      pend_steps <= pend_st_n;
      seam <= seam_n;
      start_calc <= start_calc_n;
      load_speeds <= load_n;
      global_abort <= ga_n;
      done <= done_n;
      busy <= busy_n;
      err_overflow <= eo_n;
      err_underrun <= eu_n;
      err_abort <= ea_n;
    end
  end
endmodule
